// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: accepts a byte on a valid/ready handshake and serializes it LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity symbol between data bit 7 and the stop bit.
module uart_transmitter #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out
);

  localparam int SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE;
  localparam int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME);
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] LAST_COUNT =
      CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);

  generate
    if (SYMBOL_EDGE_TIME < 2) begin : g_bad_rate
      $error("uart_transmitter: CLOCK_FREQ/BAUD_RATE must be at least 2");
    end
  endgenerate

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  state_t                         state_q, state_d;
  logic [CLOCK_COUNTER_WIDTH-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]                     bit_idx_q, bit_idx_d;
  logic [7:0]                     shift_q, shift_d;
  logic                           serial_out_q, serial_out_d;
  logic                           symbol_done;

  assign symbol_done   = (baud_cnt_q == LAST_COUNT);
  assign data_in_ready = (state_q == IDLE);
  assign serial_out    = serial_out_q;

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;

    // Counter free-runs in every symbol state; wrap marks the symbol boundary.
    if (state_q == IDLE) begin
      baud_cnt_d = '0;
    end else if (symbol_done) begin
      baud_cnt_d = '0;
    end else begin
      baud_cnt_d = baud_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        bit_idx_d = 3'd0;
        if (data_in_valid) begin
          shift_d = data_in;
          state_d = START;
        end
      end
      START: begin
        if (symbol_done) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (symbol_done) begin
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (symbol_done) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (symbol_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line level is derived from the next state so the pin is a clean flop output.
  always_comb begin
    serial_out_d = 1'b1;
    case (state_d)
      IDLE:   serial_out_d = 1'b1;
      START:  serial_out_d = 1'b0;
      DATA:   serial_out_d = shift_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
      PARITY: serial_out_d = ^shift_d;
`endif
      STOP:   serial_out_d = 1'b1;
      default: serial_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      baud_cnt_q   <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'd0;
      serial_out_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      serial_out_q <= serial_out_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter at 10 clocks per bit.
// Honours UART_TX_PARITY_EN to expect the extra parity symbol.
module tb_uart_transmitter;

  localparam int CF  = 1000;
  localparam int BR  = 100;
  localparam int SET = CF / BR;
`ifdef UART_TX_PARITY_EN
  localparam int NSYM = 11;
`else
  localparam int NSYM = 10;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic       serial_out;

  int checks;
  int errors;

  uart_transmitter #(
    .CLOCK_FREQ(CF),
    .BAUD_RATE (BR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .serial_out   (serial_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level for symbol number sym of a frame carrying b.
  function automatic logic model_bit(input logic [7:0] b, input int sym);
    if (sym == 0) return 1'b0;
    if (sym <= 8) return b[sym-1];
`ifdef UART_TX_PARITY_EN
    if (sym == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk1({tag, "_line"}, serial_out, 1'b1);
      chk1({tag, "_ready"}, data_in_ready, 1'b1);
    end
  endtask

  // Sends b and checks every cycle of the frame; stop_k > 0 returns after that cycle.
  task automatic frame(input logic [7:0] b, input bit keep_valid, input int inject_k,
                       input logic [7:0] inject_b, input int stop_k);
    logic [7:0] dec;
    int sym;
    dec = 8'h00;
    chk1("ready_pre", data_in_ready, 1'b1);
    data_in       = b;
    data_in_valid = 1'b1;
    for (int k = 1; k <= NSYM * SET; k++) begin
      @(negedge clk);
      if (k == 1) data_in_valid = keep_valid;
      if (inject_k != 0 && k == inject_k) begin
        data_in       = inject_b;
        data_in_valid = 1'b1;
      end
      if (inject_k != 0 && k == inject_k + 1) begin
        data_in       = b;
        data_in_valid = keep_valid;
      end
      sym = (k - 1) / SET;
      chk1("line", serial_out, model_bit(b, sym));
      chk1("ready_busy", data_in_ready, 1'b0);
      if (((k - 1) % SET) == SET / 2 && sym >= 1 && sym <= 8) dec[sym-1] = serial_out;
      if (k == stop_k) return;
    end
    @(negedge clk);
    chk8("decoded", dec, b);
    chk1("ready_post", data_in_ready, 1'b1);
    chk1("line_gap", serial_out, 1'b1);
    $display("tx byte %02h done at t=%0t", b, $time);
  endtask

  task automatic mid_reset(input logic [7:0] b, input int stop_k);
    frame(b, 1'b0, 0, 8'h00, stop_k);
    rst = 1'b1;
    #1;
    chk1("rst_async_line", serial_out, 1'b1);
    chk1("rst_async_ready", data_in_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_cycles("post_rst", 40);
    $display("mid-frame reset of %02h at cycle %0d checked", b, stop_k);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    data_in       = 8'h00;
    data_in_valid = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("in_rst_line", serial_out, 1'b1);
      chk1("in_rst_ready", data_in_ready, 1'b1);
    end
    rst = 1'b0;
    idle_cycles("idle", 50);
    $display("reset/idle checked");

    frame(8'hA5, 1'b0, 0, 8'h00, 0);

    // Back-to-back: valid stays high, second start must follow a one-cycle gap.
    frame(8'h00, 1'b1, 0, 8'h00, 0);
    frame(8'hFF, 1'b0, 0, 8'h00, 0);

    // A write during DATA must be ignored.
    frame(8'h55, 1'b0, 35, 8'h3C, 0);
    idle_cycles("after_ignored", 3 * SET);

    for (int i = 0; i < 6; i++) begin
      idle_cycles("rand_gap", int'($urandom_range(0, 4)));
      frame(8'($urandom), 1'b0, 0, 8'h00, 0);
    end

    mid_reset(8'h0F, 4 * SET + 5);
    mid_reset(8'($urandom), 5);

    // Handshake coinciding with reset: byte is dropped.
    @(negedge clk);
    data_in       = 8'h81;
    data_in_valid = 1'b1;
    rst           = 1'b1;
    @(negedge clk);
    rst           = 1'b0;
    data_in_valid = 1'b0;
    idle_cycles("rst_vs_hs", 30);
    $display("handshake during reset checked");

    frame(8'h07, 1'b0, 0, 8'h00, 0);
    frame(8'h03, 1'b0, 0, 8'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
